// File: rtl/avmm_axis_pkg.sv
`default_nettype none
// ============================================================================
// Package  : avmm_axis_pkg
// Brief    : Shared FSM state type and address-step helpers for the burst reader
// Revision : 1.0
// ============================================================================
package avmm_axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int bytes_per_beat(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int addr_step(input int burst_len, input int data_width);
        return burst_len * bytes_per_beat(data_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : avmm_rd_fifo
// Brief    : First-word-fall-through FIFO with occupancy count
// Revision : 1.0
// ============================================================================
module avmm_rd_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/avmm_axis_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : avmm_axis_burst_reader
// Brief    : Credit-controlled Avalon-MM burst reader streaming out over AXIS
// Revision : 1.0
// ============================================================================
module avmm_axis_burst_reader
    import avmm_axis_pkg::*;
#(
    parameter int DATA_WIDTH       = 128,
    parameter int ADDRESS_WIDTH    = 27,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int BURST_LEN        = 28,
    parameter int FIFO_DEPTH       = 64,
    parameter int NUM_BURSTS_WIDTH = 16
) (
    input  logic                          user_clk,
    input  logic                          user_reset,
    input  logic                          start,
    input  logic [ADDRESS_WIDTH-1:0]      base_address,
    input  logic [NUM_BURSTS_WIDTH-1:0]   num_bursts,
    output logic                          busy,
    output logic                          done,
    input  logic                          amm_ready,
    output logic                          amm_read,
    output logic [ADDRESS_WIDTH-1:0]      amm_address,
    output logic [BURSTCOUNT_WIDTH-1:0]   amm_burstcount,
    output logic [DATA_WIDTH/8-1:0]       amm_byteenable,
    input  logic [DATA_WIDTH-1:0]         amm_readdata,
    input  logic                          amm_readdatavalid,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = NUM_BURSTS_WIDTH + BURSTCOUNT_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(addr_step(BURST_LEN, DATA_WIDTH));
    localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW:0]   BURST_EXT = (CW+1)'(BURST_LEN);
    localparam logic [CW-1:0] BURST_CW  = CW'(BURST_LEN);

    state_t                        state;
    state_t                        state_next;
    logic [ADDRESS_WIDTH-1:0]      addr;
    logic [NUM_BURSTS_WIDTH-1:0]   bursts_left;
    logic [CW-1:0]                 outstanding;
    logic [BW-1:0]                 beat_cnt;
    logic [BW-1:0]                 last_beat;
    logic                          zero_done;

    logic [CW-1:0]                 fifo_count;
    logic                          fifo_empty;
    logic [DATA_WIDTH-1:0]         fifo_head;

    logic                          push;
    logic                          pop;
    logic                          accept;
    logic                          start_job;
    logic                          start_zero;
    logic [CW:0]                   credit_used;
    logic [CW:0]                   credit_free;
    logic                          credit_ok;

    assign push        = amm_readdatavalid && (state != IDLE);
    assign pop         = m_axis_tvalid && m_axis_tready;
    assign accept      = amm_read && amm_ready;
    assign start_job   = (state == IDLE) && start && (num_bursts != '0);
    assign start_zero  = (state == IDLE) && start && (num_bursts == '0);
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit_free = DEPTH_EXT - credit_used;
    assign credit_ok   = (credit_free >= BURST_EXT);

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        amm_read   = 1'b0;
        case (state)
            IDLE: begin
                if (start_job) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                amm_read = credit_ok;
                if (amm_read && amm_ready && (bursts_left == NUM_BURSTS_WIDTH'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            addr        <= '0;
            bursts_left <= '0;
            outstanding <= '0;
            beat_cnt    <= '0;
            last_beat   <= '0;
            zero_done   <= 1'b0;
        end else begin
            zero_done <= start_zero;
            if (start_job) begin
                addr        <= base_address;
                bursts_left <= num_bursts;
                outstanding <= '0;
                beat_cnt    <= '0;
                last_beat   <= BW'(num_bursts) * BW'(BURST_LEN) - BW'(1);
            end else begin
                if (accept) begin
                    addr        <= addr + ADDR_STEP;
                    bursts_left <= bursts_left - NUM_BURSTS_WIDTH'(1);
                end
                // Accept and return can coincide; both apply in one update.
                outstanding <= outstanding + (accept ? BURST_CW : CW'(0)) - CW'(push);
                if (pop) begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
        end
    end

    avmm_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (user_clk),
        .rst       (user_reset),
        .push      (push),
        .push_data (amm_readdata),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_axis_tvalid  = !fifo_empty;
    assign m_axis_tdata   = m_axis_tvalid ? fifo_head : '0;
    assign m_axis_tlast   = m_axis_tvalid && (state != IDLE) && (beat_cnt == last_beat);
    assign done           = zero_done || ((state == DRAIN) && pop && m_axis_tlast);
    assign busy           = (state != IDLE);
    assign amm_address    = addr;
    assign amm_burstcount = BURSTCOUNT_WIDTH'(BURST_LEN);
    assign amm_byteenable = '1;

endmodule
`default_nettype wire

// File: tb/tb_avmm_axis_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_avmm_axis_burst_reader
// Brief    : Randomised bench with a transaction-level memory and stream model
// Revision : 1.0
// ============================================================================
module tb_avmm_axis_burst_reader;

    localparam int DW = 128;
    localparam int AW = 27;
    localparam int BCW = 7;
    localparam int BL = 28;
    localparam int DEPTH = 64;
    localparam int NBW = 16;

    logic            user_clk;
    logic            user_reset;
    logic            start;
    logic [AW-1:0]   base_address;
    logic [NBW-1:0]  num_bursts;
    logic            busy;
    logic            done;
    logic            amm_ready;
    logic            amm_read;
    logic [AW-1:0]   amm_address;
    logic [BCW-1:0]  amm_burstcount;
    logic [DW/8-1:0] amm_byteenable;
    logic [DW-1:0]   amm_readdata;
    logic            amm_readdatavalid;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;

    avmm_axis_burst_reader dut (
        .user_clk          (user_clk),
        .user_reset        (user_reset),
        .start             (start),
        .base_address      (base_address),
        .num_bursts        (num_bursts),
        .busy              (busy),
        .done              (done),
        .amm_ready         (amm_ready),
        .amm_read          (amm_read),
        .amm_address       (amm_address),
        .amm_burstcount    (amm_burstcount),
        .amm_byteenable    (amm_byteenable),
        .amm_readdata      (amm_readdata),
        .amm_readdatavalid (amm_readdatavalid),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Job-level model state
    bit            active;
    bit            zero_pend;
    int            job_n, total, issued, pushed, popped, job_id;
    logic [AW-1:0] job_base;
    int            cyc;
    logic [AW-1:0] acc_addr [16];
    int            acc_cnt, tot_acc, tot_pop;
    int            tlast_idx, done_cyc, last_pop_cyc, stall_cnt, start_cyc;

    // Stimulus modes
    int tready_mode, ready_mode, gap_pct, lat;
    bit stray_mode;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
        int            id;
    } beat_t;
    beat_t q[$];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input int id);
        logic [31:0] w;
        w = 32'(a);
        return {w, w ^ 32'hDEADBEEF, 32'(id), w * 32'd3 + 32'h55};
    endfunction

    initial begin
        bit            nx_ready, nx_rdv, nx_tready;
        logic [DW-1:0] nx_data;
        int            fifo_m, out_m;
        bit            exp_read, exp_valid, exp_pop, exp_done, was_active, prev_wait;
        logic [AW-1:0] prev_addr, ea;
        beat_t         b;
        nx_ready = 0; nx_rdv = 0; nx_tready = 0; nx_data = '0;
        prev_wait = 0; prev_addr = '0;
        amm_ready = 0; amm_readdatavalid = 0; amm_readdata = '0; m_axis_tready = 0;
        forever begin
            @(negedge user_clk);
            amm_ready = nx_ready;
            amm_readdatavalid = nx_rdv;
            amm_readdata = nx_data;
            m_axis_tready = nx_tready;
            #4;
            cyc++;
            if (user_reset) begin
                check("rst_amm_read", amm_read, 0);
                check("rst_amm_address", amm_address, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_tvalid", m_axis_tvalid, 0);
                check("rst_tlast", m_axis_tlast, 0);
                check("rst_tdata", m_axis_tdata, 0);
                active = 0; zero_pend = 0; issued = 0; pushed = 0; popped = 0; job_n = 0;
                q.delete();
                prev_wait = 0;
                nx_rdv = 0;
            end else begin
                was_active = active;
                fifo_m = pushed - popped;
                out_m = issued * BL - pushed;
                exp_read = active && (issued < job_n) && ((DEPTH - (fifo_m + out_m)) >= BL);
                exp_valid = fifo_m > 0;
                exp_pop = exp_valid && m_axis_tready;
                exp_done = zero_pend || (active && exp_pop && (popped == total - 1));
                check("amm_read", amm_read, exp_read);
                check("busy", busy, active);
                check("tvalid", m_axis_tvalid, exp_valid);
                check("done", done, exp_done);
                if (exp_valid) begin
                    ea = job_base + AW'(popped * 16);
                    check("tdata", m_axis_tdata, mem_word(ea, job_id));
                    check("tlast", m_axis_tlast, popped == total - 1);
                end
                if (prev_wait) begin
                    check("hold_read", amm_read, 1);
                    check("hold_address", amm_address, prev_addr);
                end
                prev_wait = amm_read && !amm_ready;
                prev_addr = amm_address;
                if (amm_read && !amm_ready && ready_mode == 2 && issued == 1) begin
                    stall_cnt++;
                    check("stall_address", amm_address, job_base + AW'(448));
                end
                if (amm_read && amm_ready) begin
                    ea = job_base + AW'(issued * 448);
                    check("accept_address", amm_address, ea);
                    check("burstcount", amm_burstcount, BCW'(BL));
                    check("byteenable", amm_byteenable, {(DW/8){1'b1}});
                    if (acc_cnt < 16) acc_addr[acc_cnt] = amm_address;
                    acc_cnt++; tot_acc++; issued++;
                    for (int i = 0; i < BL; i++) begin
                        b.a = amm_address + AW'(i * 16);
                        b.due = cyc + lat;
                        b.id = job_id;
                        q.push_back(b);
                    end
                end
                if (amm_readdatavalid && active) pushed++;
                if (exp_pop) begin
                    if (m_axis_tlast) tlast_idx = popped;
                    popped++; tot_pop++;
                    last_pop_cyc = cyc;
                    if (popped == total) active = 0;
                end
                if (done) done_cyc = cyc;
                zero_pend = 0;
                if (start && !was_active) begin
                    start_cyc = cyc;
                    if (num_bursts != 0) begin
                        active = 1; job_n = int'(num_bursts); total = job_n * BL;
                        job_base = base_address; issued = 0; pushed = 0; popped = 0;
                        acc_cnt = 0; job_id++;
                    end else begin
                        zero_pend = 1;
                    end
                end
            end
            // Plan next cycle's slave-side and sink-side inputs
            case (tready_mode)
                0: nx_tready = 1;
                1: nx_tready = 0;
                default: nx_tready = ($urandom_range(1) == 1);
            endcase
            case (ready_mode)
                0: nx_ready = 1;
                1: nx_ready = ($urandom_range(2) != 0);
                default: nx_ready = !(issued == 1 && stall_cnt < 5);
            endcase
            if (!user_reset && q.size() > 0 && q[0].due <= cyc + 1 && $urandom_range(99) >= gap_pct) begin
                nx_rdv = 1;
                nx_data = mem_word(q[0].a, q[0].id);
                void'(q.pop_front());
            end else if (stray_mode) begin
                nx_rdv = 1;
                nx_data = {4{$urandom}};
            end else begin
                nx_rdv = 0;
                nx_data = '0;
            end
        end
    end

    task automatic start_job(input logic [AW-1:0] b, input int n);
        @(negedge user_clk);
        start = 1; base_address = b; num_bursts = NBW'(n);
        @(negedge user_clk);
        start = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge user_clk);
            if (!active && !zero_pend) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got busy expected idle within %0d cycles", name, budget);
        end
    endtask

    task automatic run_job(input string name, input logic [AW-1:0] b, input int n);
        start_job(b, n);
        wait_idle(name, 4000);
    endtask

    initial begin
        logic [AW-1:0] rb;
        int            n, acc_before, pop_before;
        user_reset = 1; start = 0; base_address = '0; num_bursts = '0;
        tready_mode = 0; ready_mode = 0; gap_pct = 0; lat = 2; stray_mode = 0;
        repeat (3) @(negedge user_clk);
        user_reset = 0;
        repeat (2) @(negedge user_clk);

        // Basic three-burst job
        done_cyc = -1;
        run_job("basic", '0, 3);
        check("basic_acc_cnt", acc_cnt, 3);
        check("basic_addr0", acc_addr[0], 27'h000);
        check("basic_addr1", acc_addr[1], 27'h1C0);
        check("basic_addr2", acc_addr[2], 27'h380);
        check("basic_beats", popped, 84);
        check("basic_tlast_idx", tlast_idx, 83);
        check("basic_done_cycle", done_cyc, last_pop_cyc);

        // Full back-pressure: credit stops issue after two bursts
        tready_mode = 1;
        start_job('0, 3);
        repeat (80) @(negedge user_clk);
        check("bp_accepts", acc_cnt, 2);
        check("bp_read_low", amm_read, 0);
        check("bp_fifo_fill", pushed - popped, 56);
        tready_mode = 0;
        wait_idle("bp", 4000);
        check("bp_accepts_final", acc_cnt, 3);
        check("bp_beats", popped, 84);

        // Slave stalls the second request for five cycles
        ready_mode = 2; stall_cnt = 0;
        run_job("stall", '0, 3);
        ready_mode = 0;
        check("stall_cycles", stall_cnt, 5);
        check("stall_accepts", acc_cnt, 3);

        // Address wrap
        run_job("wrap", 27'h7FFFE40, 2);
        check("wrap_addr0", acc_addr[0], 27'h7FFFE40);
        check("wrap_addr1", acc_addr[1], 27'h0000000);

        // Zero-length job
        acc_before = tot_acc; pop_before = tot_pop; done_cyc = -1;
        start_job(27'h100, 0);
        repeat (4) @(negedge user_clk);
        check("zero_done_cycle", done_cyc, start_cyc + 1);
        check("zero_no_reads", tot_acc, acc_before);
        check("zero_no_beats", tot_pop, pop_before);

        // Start while busy is ignored
        start_job('0, 2);
        repeat (10) @(negedge user_clk);
        start_job(27'h5000, 1);
        wait_idle("busy_start", 4000);
        check("busy_start_accepts", acc_cnt, 2);
        check("busy_start_addr1", acc_addr[1], 27'h1C0);

        // Reset during DRAIN, stray returns while idle, then a clean job
        tready_mode = 1;
        start_job(27'h40, 2);
        repeat (40) @(negedge user_clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_accepts", acc_cnt, 2);
        @(negedge user_clk);
        user_reset = 1;
        repeat (2) @(negedge user_clk);
        user_reset = 0;
        tready_mode = 0;
        stray_mode = 1;
        repeat (5) @(negedge user_clk);
        stray_mode = 0;
        repeat (3) @(negedge user_clk);
        run_job("post_rst", 27'h40, 2);
        check("post_rst_beats", popped, 56);

        // Randomised jobs
        for (int k = 0; k < 8; k++) begin
            tready_mode = 2; ready_mode = 1;
            gap_pct = $urandom_range(40);
            lat = $urandom_range(6, 1);
            rb = AW'($urandom);
            rb[3:0] = 4'h0;
            n = $urandom_range(4, 1);
            run_job("random", rb, n);
            check("random_beats", popped, n * BL);
            check("random_accepts", acc_cnt, n);
        end

        repeat (3) @(negedge user_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
